// File: rtl/seven_segment_capture_if.sv
// seven_segment_capture_if: scan inputs and reconstructed display state between the capture block and its users
interface seven_segment_capture_if;
    logic [7:0]  pos;
    logic [7:0]  segments;
    logic [31:0] digit;
    logic [7:0]  en_digit;
    logic [7:0]  en_dot;
    logic        frame_done;
    logic        decode_err;
    logic        pos_err;
    logic        timeout;
    modport slave (
        input  pos, segments,
        output digit, en_digit, en_dot, frame_done, decode_err, pos_err, timeout
    );
    modport master (
        output pos, segments,
        input  digit, en_digit, en_dot, frame_done, decode_err, pos_err, timeout
    );
endinterface

// File: rtl/seven_segment_capture.sv
// seven_segment_capture: rebuilds the 8-digit hex value, dot and digit enables from a multiplexed seven-segment scan
module seven_segment_capture #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input logic clk,
    input logic rst,
    seven_segment_capture_if.slave bus
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [6:0] SEG_TBL [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic [15:0]   sync1, s_in, held;
    logic [SW-1:0] stab_cnt;
    logic [TW-1:0] tmo_cnt;
    logic [7:0]    seen, seen_nxt;
    logic [2:0]    idx;
    logic [3:0]    val;
    logic          accept, one_hot, idle, match, blank, upd, frame;
    always_comb begin
        accept = stab_cnt == SW'(STABLE_CYCLES - 1) && s_in == held;
        idle = held[15:8] == 8'hFF;
        one_hot = $onehot(~held[15:8]);
        blank = held[7:1] == 7'h7F;
        idx = '0;
        for (int k = 0; k < 8; k++) idx = held[8+k] ? idx : 3'(k);
        match = 1'b0;
        val = '0;
        for (int k = 0; k < 16; k++) begin
            match = match | (held[7:1] == SEG_TBL[k]);
            val = held[7:1] == SEG_TBL[k] ? 4'(k) : val;
        end
        upd = accept && one_hot && (match || blank);
        seen_nxt = seen | (8'b1 << idx);
        frame = seen_nxt == 8'hFF;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1 <= '0;
            s_in <= '0;
            held <= '0;
            stab_cnt <= '0;
            tmo_cnt <= '0;
            seen <= '0;
            bus.digit <= '0;
            bus.en_digit <= '0;
            bus.en_dot <= '0;
            bus.frame_done <= 1'b0;
            bus.decode_err <= 1'b0;
            bus.pos_err <= 1'b0;
            bus.timeout <= 1'b0;
        end else begin
            sync1 <= {bus.pos, bus.segments};
            s_in <= sync1;
            if (s_in != held) begin
                held <= s_in;
                stab_cnt <= '0;
            end else if (stab_cnt < SW'(STABLE_CYCLES)) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
            bus.pos_err <= accept && !idle && !one_hot;
            bus.decode_err <= accept && one_hot && !match && !blank;
            bus.frame_done <= upd && frame;
            // a valid accept outranks the timeout firing on the same edge
            if (accept && one_hot) begin
                tmo_cnt <= '0;
                bus.timeout <= 1'b0;
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                tmo_cnt <= TW'(TIMEOUT_CYCLES);
                bus.timeout <= 1'b1;
                bus.en_digit <= '0;
                bus.en_dot <= '0;
                seen <= '0;
            end else if (tmo_cnt != TW'(TIMEOUT_CYCLES)) begin
                tmo_cnt <= tmo_cnt + 1'b1;
            end
            if (upd) begin
                if (match) bus.digit[{idx, 2'b00} +: 4] <= val;
                bus.en_digit[idx] <= match;
                bus.en_dot[idx] <= match & ~held[0];
                seen <= frame ? 8'h00 : seen_nxt;
            end
        end
    end
endmodule

// File: tb/tb_seven_segment_capture.sv
// tb_seven_segment_capture: directed and random scans against a step-level model of the capture
module tb_seven_segment_capture;
    localparam int STB = 4;
    localparam int TMO = 64;
    localparam logic [6:0] SEG_TB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };
    logic clk = 1'b0;
    logic rst = 1'b0;
    int cyc = 0;
    int ncmp = 0;
    int nfail = 0;
    int o_fd = 0, o_de = 0, o_pe = 0;
    int m_fd = 0, m_de = 0, m_pe = 0;
    logic [3:0] m_dig [8];
    logic [7:0] m_en, m_dot, m_seen;
    logic m_tmo;
    int last_clr;
    logic [15:0] last_pat;
    logic [7:0] p_r, s_r;
    int r;
    seven_segment_capture_if bus();
    seven_segment_capture #(.STABLE_CYCLES(STB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (bus.frame_done === 1'b1) o_fd++;
        if (bus.decode_err === 1'b1) o_de++;
        if (bus.pos_err === 1'b1) o_pe++;
    end
    function automatic logic [7:0] seg_of(input int v, input bit dp);
        return {SEG_TB[v], ~dp};
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask
    task automatic chk_state(input string tag);
        logic [31:0] d;
        for (int i = 0; i < 8; i++) d[4*i +: 4] = m_dig[i];
        chk({tag, " digit"}, bus.digit, d);
        chk({tag, " en_digit"}, {24'h0, bus.en_digit}, {24'h0, m_en});
        chk({tag, " en_dot"}, {24'h0, bus.en_dot}, {24'h0, m_dot});
        chk({tag, " timeout"}, {31'h0, bus.timeout}, {31'h0, m_tmo});
        chk({tag, " frame_done count"}, o_fd, m_fd);
        chk({tag, " decode_err count"}, o_de, m_de);
        chk({tag, " pos_err count"}, o_pe, m_pe);
    endtask
    task automatic tmo_upto(input int e);
        if (!m_tmo && last_clr + TMO <= e) begin
            m_tmo = 1'b1;
            m_en = '0;
            m_dot = '0;
            m_seen = '0;
        end
    endtask
    task automatic model_accept(input logic [7:0] p, input logic [7:0] s, input int a);
        int i, v;
        if (p == 8'hFF) return;
        if ($countones(~p) != 1) begin
            m_pe++;
            return;
        end
        for (int k = 0; k < 8; k++) if (!p[k]) i = k;
        last_clr = a;
        m_tmo = 1'b0;
        v = -1;
        for (int k = 0; k < 16; k++) if (s[7:1] == SEG_TB[k]) v = k;
        if (v < 0 && s[7:1] != 7'h7F) begin
            m_de++;
            return;
        end
        if (v >= 0) m_dig[i] = 4'(v);
        m_en[i] = v >= 0;
        m_dot[i] = v >= 0 && !s[0];
        m_seen[i] = 1'b1;
        if (m_seen == 8'hFF) begin
            m_fd++;
            m_seen = '0;
        end
    endtask
    // drive one pattern for n edges; an accepted change updates outputs on edge start+STB+3
    task automatic step(input logic [7:0] p, input logic [7:0] s, input int n);
        int st;
        bit acc;
        st = cyc;
        acc = n >= STB + 4 && {p, s} != last_pat;
        last_pat = {p, s};
        bus.pos = p;
        bus.segments = s;
        if (acc) begin
            repeat (STB + 2) begin @(posedge clk); #1; end
            tmo_upto(st + STB + 2);
            chk_state("pre-accept");
            model_accept(p, s, st + STB + 3);
        end
        repeat (acc ? n - STB - 2 : n) begin @(posedge clk); #1; end
        tmo_upto(st + n);
        chk_state("post");
    endtask
    task automatic do_reset(input int n);
        rst = 1'b0;
        bus.pos = 8'hFF;
        bus.segments = 8'hFF;
        repeat (n) begin @(posedge clk); #1; end
        for (int i = 0; i < 8; i++) m_dig[i] = '0;
        m_en = '0;
        m_dot = '0;
        m_seen = '0;
        m_tmo = 1'b0;
        last_clr = cyc;
        last_pat = '0;
        chk_state("reset");
        chk("reset frame_done", {31'h0, bus.frame_done}, 32'h0);
        chk("reset decode_err", {31'h0, bus.decode_err}, 32'h0);
        chk("reset pos_err", {31'h0, bus.pos_err}, 32'h0);
        rst = 1'b1;
    endtask
    initial begin
        do_reset(3);
        step(8'hFE, 8'b10011111, 10);
        for (int i = 0; i < 8; i++) step(8'(~(8'h1 << i)), seg_of(i, i == 2 || i == 5), 10);
        chk("frame digit", bus.digit, 32'h76543210);
        chk("frame en_dot", {24'h0, bus.en_dot}, 32'h24);
        step(8'hFD, 8'b00100101, 3);
        step(8'h7F, seg_of(7, 0), 10);
        step(8'hF7, 8'hFF, 10);
        step(8'hF7, 8'b01010101, 10);
        step(8'hFC, 8'b01010101, 10);
        for (int k = 0; k < 24; k++) begin
            do begin
                r = $urandom_range(0, 9);
                p_r = r == 0 ? 8'hFF : r == 1 ? 8'(~(8'h3 << $urandom_range(0, 6))) : 8'(~(8'h1 << $urandom_range(0, 7)));
                r = $urandom_range(0, 9);
                s_r = r == 0 ? 8'($urandom) : r == 1 ? {7'h7F, 1'($urandom)} : seg_of($urandom_range(0, 15), 1'($urandom));
            end while ({p_r, s_r} == last_pat);
            step(p_r, s_r, $urandom_range(8, 14));
        end
        for (int i = 0; i < 8; i++) step(8'(~(8'h1 << i)), seg_of(i + 8, 1'($urandom)), 10);
        step(8'hFF, 8'hFF, 60);
        repeat (10) step(8'hFF, 8'hFF, 1);
        chk("timeout level", {31'h0, bus.timeout}, 32'h1);
        step(8'hFB, seg_of(5, 1), 10);
        for (int i = 0; i < 4; i++) step(8'(~(8'h1 << i)), seg_of(15 - i, 0), 10);
        do_reset(2);
        for (int i = 0; i < 8; i++) step(8'(~(8'h1 << (7 - i))), seg_of($urandom_range(0, 15), 1'($urandom)), 10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
